// File: rtl/y86_bus_arbiter_pkg.sv
// Shared types and constants for the y86 two-port memory bus arbiter.
package y86_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } arb_state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
  localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/y86_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = requesters/memory view.
interface y86_bus_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;

  logic [DW-1:0] rdata;
  logic          err;
  logic [1:0]    gnt;

  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_out;
  logic          mem_WE;
  logic          mem_RE;
  logic [DW-1:0] mem_in;
  logic          mem_ready;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_in, mem_ready,
    output r0_ack, r1_ack, rdata, err, gnt,
    output mem_A, mem_out, mem_WE, mem_RE
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_in, mem_ready,
    input  r0_ack, r1_ack, rdata, err, gnt,
    input  mem_A, mem_out, mem_WE, mem_RE
  );

endinterface

// File: rtl/y86_bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker; on a tie the port not served last wins.
module y86_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       any
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end
    any = |req;
  end

endmodule

// File: rtl/y86_bus_arbiter.sv
// Serialises two requesters onto one single-ported memory with round-robin
// fairness, mem_ready wait states and a bounded-wait timeout.
module y86_bus_arbiter
  import y86_bus_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  y86_bus_arbiter_if.slave  bus
);

  arb_state_t       r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_gnt;
  logic [1:0]       r_ack;
  logic             r_err;
  logic [DW-1:0]    r_rdata;
  logic [AW-1:0]    r_mem_a;
  logic [DW-1:0]    r_mem_out;
  logic             r_mem_we;
  logic             r_mem_re;

  logic [1:0]       w_req;
  logic [1:0]       w_win;
  logic             w_any;

  assign w_req = {bus.r1_req, bus.r0_req};

  y86_rr_pick u_pick (
    .req  (w_req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_mem_a   <= '0;
      r_mem_out <= '0;
      r_mem_we  <= 1'b0;
      r_mem_re  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt     <= w_win;
            r_cnt     <= '0;
            r_mem_a   <= w_win[1] ? bus.r1_addr  : bus.r0_addr;
            r_mem_out <= w_win[1] ? bus.r1_wdata : bus.r0_wdata;
            r_mem_we  <= w_win[1] ? bus.r1_we    : bus.r0_we;
            r_mem_re  <= w_win[1] ? !bus.r1_we   : !bus.r0_we;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          // mem_ready wins over the timeout when both land in the last wait cycle
          if (bus.mem_ready) begin
            if (r_mem_re) begin
              r_rdata <= bus.mem_in;
            end
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            r_err    <= 1'b0;
            r_ack    <= r_gnt;
            r_state  <= ACK;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rdata  <= DW'(BUS_ERR_DATA);
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            r_err    <= 1'b1;
            r_ack    <= r_gnt;
            r_state  <= ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACK: begin
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_last  <= r_gnt[1];
          r_gnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.r0_ack  = r_ack[0];
  assign bus.r1_ack  = r_ack[1];
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
  assign bus.gnt     = r_gnt;
  assign bus.mem_A   = r_mem_a;
  assign bus.mem_out = r_mem_out;
  assign bus.mem_WE  = r_mem_we;
  assign bus.mem_RE  = r_mem_re;

endmodule

// File: doc/y86_bus_arbiter.md
# y86_bus_arbiter

Two-port memory bus arbiter that shares one single-ported memory between two requesters: port 0 for the y86 core's fetch/load/store traffic, and port 1 for a debug/DMA loader. It serialises accesses and applies round-robin fairness. It tolerates variable memory latency through a `mem_ready` handshake, and it bounds every access with a timeout. It sits between the requesters and the memory, replacing the direct core-to-memory bus connection.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 15: maximum wait cycles in BUSY before an access aborts. Legal range 1..255.

- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rK_req`  in  1  (K=0,1) access request, held until `rK_ack`.
- `rK_we`  in  1  1 = write, 0 = read; stable while `rK_req`.
- `rK_addr`  in  AW  access address; stable while `rK_req`.
- `rK_wdata`  in  DW  write data; stable while `rK_req`.
- `rK_ack`  out  1  one-cycle completion pulse to port K.
- `rdata`  out  DW  read data; valid in the `ack` cycle, shared by both ports.
- `err`  out  1  asserted with `ack` when the access timed out.
- `gnt`  out  2  one-hot owner while BUSY; 0 otherwise.
- `mem_A`  out  AW  memory address.
- `mem_out`  out  DW  memory write data.
- `mem_WE`, `mem_RE`  out  1  memory strobes; at most one is high.
- `mem_in`  in  DW  memory read data, sampled when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current strobe this cycle.

## Operation
- **FSM states:** IDLE, BUSY, ACK.
- **IDLE:**
  - If any `req` is high, the picker selects the winner:
    - If only one port requests, that port wins.
    - If both request, the port not served last wins. The last-served pointer resets to 1, so port 0 wins the first tie.
  - On winning, the block latches address, wdata and we, and sets `gnt`.
  - It raises `mem_WE` or `mem_RE` from the next cycle and moves to BUSY.
- **BUSY:**
  - The strobe, `mem_A` and `mem_out` are held constant.
  - The wait counter increments each cycle.
  - On `mem_ready`=1:
    - Strobes drop at the next edge.
    - For reads, `rdata` latches `mem_in`.
    - The FSM moves to ACK with `err`=0.
  - If the counter reaches TIMEOUT without `mem_ready`:
    - Strobes drop at the next edge.
    - `rdata` is set to 32'hDEAD_BEEF.
    - The FSM moves to ACK with `err`=1.
- **ACK:**
  - `rK_ack` is pulsed for exactly one cycle for the owner.
  - The last-served pointer updates to the owner.
  - `gnt` clears and the FSM returns to IDLE.
- **Requester rule:** the requester may drop `req` in the cycle after `ack`, or keep it high to request again. A request still high in IDLE competes normally, so alternating ports interleave fairly.
- **Write data:** `rdata` retains its last value after a write access.
- **`mem_ready` outside BUSY** is ignored.
- **Reset mid-access:** outputs return to their reset values at the reset edge. No ack is issued, and the pending access is lost. The requester must re-issue it.
- **Reset values:**
  - FSM = IDLE, pointer = 1, counter = 0.
  - `gnt`=0, `r0_ack`=`r1_ack`=0, `err`=0, `rdata`=0.
  - `mem_WE`=`mem_RE`=0, `mem_A`=0, `mem_out`=0.

## Timing
- Registered outputs only; there is no combinational path from `req` or `mem_ready` to any output.
- **Zero-wait access:**
  - `req` high in cycle n (IDLE).
  - Strobe and `gnt` appear in n+1.
  - `mem_ready` arrives in n+1.
  - `ack` and `rdata` appear in n+2.
  - IDLE is reached at n+3.
- **Throughput:** one access per 3 cycles plus memory wait cycles.
- **Wait states:** W wait cycles add W cycles to the ack.
- **Timeout:** the strobe is high for exactly TIMEOUT cycles, and `ack` with `err`=1 follows one cycle later.
- **Strobe cleanliness:** `mem_WE` and `mem_RE` never glitch and are never both 1.

## Structure
- **Package `y86_bus_pkg`:**
  - State enum {IDLE, BUSY, ACK}.
  - `BUS_ERR_DATA` = 32'hDEAD_BEEF.
  - Timeout counter width (8).
- **Sub-module `y86_rr_pick`:** purely combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot win[1:0], any.
- The top level holds the FSM, address/data latches, wait counter and pointer.

## Test plan
- **Single read, port 0, zero wait:** `r0_req`, addr 0x10, memory returns 0x1234_5678 with `mem_ready` in the first strobe cycle → `mem_RE` for 1 cycle; `r0_ack` and `rdata`=0x1234_5678 two cycles after req; `err`=0.
- **Simultaneous requests held high, 4 accesses:** → grant order 0,1,0,1; `gnt` one-hot; no overlapping strobes.
- **Port 1 write, 3 wait states:** addr 0x40, wdata 0xA5A5_A5A5 → `mem_WE` high 4 cycles with stable addr/data; `r1_ack` the cycle after `mem_ready`; `rdata` unchanged.
- **Timeout:** TIMEOUT=15, `mem_ready` held 0 → strobe high exactly 15 cycles; then `ack`, `err`=1, `rdata`=0xDEAD_BEEF; the next access succeeds normally.
- **Reset mid-BUSY:** `rst_n` low while `mem_RE`=1 → all outputs at reset values the next cycle; no ack; after release, the port 0 tie-break holds.
- **`mem_ready` pulses while IDLE:** → no ack, no state change.
